// File: rtl/fpu_arb_pkg.sv
// rtl/fpu_arb_pkg.sv - shared types and constants for the FPU arbiter
package fpu_arb_pkg;

  localparam int FPU_DATA_W         = 32;
  localparam int FPU_OPSEL_W        = 3;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin pick starting at ptr
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one FPU between NUM_REQ requesters
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_op1,
  input  logic [NUM_REQ*FPU_DATA_W-1:0]  req_op2,
  input  logic [NUM_REQ*FPU_OPSEL_W-1:0] req_op_select,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [FPU_DATA_W-1:0]          resp_result,
  output logic                           resp_error,
  output logic                           busy,
  output logic                           fpu_enable,
  output logic [FPU_DATA_W-1:0]          fpu_op1,
  output logic [FPU_DATA_W-1:0]          fpu_op2,
  output logic [FPU_OPSEL_W-1:0]         fpu_op_select,
  input  logic [FPU_DATA_W-1:0]          fpu_result,
  input  logic                           fpu_data_valid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic [IDX_W-1:0]   ptr_next;

  fpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Ready is forced low while reset is asserted so every output reads 0 in reset.
  assign req_ready = (state == IDLE && RSTN && grant_any) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != IDLE);
  assign ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef FPU_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        error_q;
  assign resp_error = error_q;
`else
  assign resp_error = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      fpu_enable    <= 1'b0;
      fpu_op1       <= '0;
      fpu_op2       <= '0;
      fpu_op_select <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      error_q       <= 1'b0;
`endif
    end else begin
      fpu_enable <= 1'b0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_op1       <= req_op1[FPU_DATA_W*int'(grant_idx) +: FPU_DATA_W];
            fpu_op2       <= req_op2[FPU_DATA_W*int'(grant_idx) +: FPU_DATA_W];
            fpu_op_select <= req_op_select[FPU_OPSEL_W*int'(grant_idx) +: FPU_OPSEL_W];
            owner         <= grant_idx;
            rr_ptr        <= ptr_next;
            fpu_enable    <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (fpu_data_valid) begin
            resp_result <= fpu_result;
            resp_valid  <= ONE_HOT0 << owner;
`ifdef FPU_ARB_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (wait_cnt == 16'(TIMEOUT_CYCLES)) begin
            resp_result <= '0;
            resp_valid  <= ONE_HOT0 << owner;
            error_q     <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - randomized self-checking bench for fpu_arbiter with a round-robin model
module tb_fpu_arbiter;

  localparam int NR = 3;
  localparam int TO = 8;

  logic            CLK;
  logic            RSTN;
  logic [NR-1:0]   req_valid;
  logic [NR*32-1:0] req_op1;
  logic [NR*32-1:0] req_op2;
  logic [NR*3-1:0]  req_op_select;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic [31:0]     resp_result;
  logic            resp_error;
  logic            busy;
  logic            fpu_enable;
  logic [31:0]     fpu_op1;
  logic [31:0]     fpu_op2;
  logic [2:0]      fpu_op_select;
  logic [31:0]     fpu_result;
  logic            fpu_data_valid;

  logic [31:0] op1_a [NR];
  logic [31:0] op2_a [NR];
  logic [2:0]  sel_a [NR];

  int tests = 0;
  int fails = 0;
  int mptr  = 0;

  fpu_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .req_valid      (req_valid),
    .req_op1        (req_op1),
    .req_op2        (req_op2),
    .req_op_select  (req_op_select),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .resp_error     (resp_error),
    .busy           (busy),
    .fpu_enable     (fpu_enable),
    .fpu_op1        (fpu_op1),
    .fpu_op2        (fpu_op2),
    .fpu_op_select  (fpu_op_select),
    .fpu_result     (fpu_result),
    .fpu_data_valid (fpu_data_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    req_op1       = '0;
    req_op2       = '0;
    req_op_select = '0;
    for (int i = 0; i < NR; i++) begin
      req_op1[32*i +: 32]     = op1_a[i];
      req_op2[32*i +: 32]     = op2_a[i];
      req_op_select[3*i +: 3] = sel_a[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++)
      if (m[(mptr + k) % NR]) return (mptr + k) % NR;
    return 0;
  endfunction

  // lat = WAIT cycle in which the FPU answers; lat == 0 means it never answers.
  task automatic do_op(input logic [NR-1:0] mask, input int lat, input bit stray);
    int g;
    int nwait;
    bit to;
    logic [31:0] r;
    logic [31:0] e1, e2;
    logic [2:0]  es;
    logic [NR-1:0] gmask;
    for (int i = 0; i < NR; i++) begin
      op1_a[i] = $urandom;
      op2_a[i] = $urandom;
      sel_a[i] = 3'($urandom_range(0, 7));
    end
    req_valid = mask;
    #1;
    g     = model_grant(mask);
    gmask = NR'(1) << g;
    check("grant", 32'(req_ready), 32'(gmask));
    e1 = op1_a[g]; e2 = op2_a[g]; es = sel_a[g];
    mptr = (g + 1) % NR;
    @(negedge CLK);
    req_valid = mask & ~gmask;
    for (int i = 0; i < NR; i++) begin
      op1_a[i] = (i == g) ? $urandom : op1_a[i];
    end
    if (stray) begin
      fpu_data_valid = 1'b1;
      fpu_result     = 32'hDEAD_BEEF;
    end
    #1;
    check("issue_en", 32'(fpu_enable), 32'd1);
    check("issue_op1", fpu_op1, e1);
    check("issue_op2", fpu_op2, e2);
    check("issue_sel", 32'(fpu_op_select), 32'(es));
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_ready", 32'(req_ready), 32'd0);
    to    = (lat == 0);
    nwait = to ? TO + 1 : lat;
    r     = $urandom;
    for (int k = 1; k <= nwait; k++) begin
      @(negedge CLK);
      fpu_data_valid = (!to && k == nwait);
      fpu_result     = fpu_data_valid ? r : $urandom;
      #1;
      check("wait_resp", 32'(resp_valid), 32'd0);
      check("wait_en", 32'(fpu_enable), 32'd0);
      check("wait_ready", 32'(req_ready), 32'd0);
    end
    @(negedge CLK);
    fpu_data_valid = 1'b0;
    #1;
    check("resp_valid", 32'(resp_valid), 32'(gmask));
    check("resp_result", resp_result, to ? 32'd0 : r);
    check("resp_error", 32'(resp_error), 32'(to));
    check("resp_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    req_valid = '0;
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_resp", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    RSTN           = 1'b0;
    req_valid      = '1;
    fpu_result     = '0;
    fpu_data_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      op1_a[i] = 32'hFFFF_FFFF; op2_a[i] = 32'hFFFF_FFFF; sel_a[i] = 3'd7;
    end
    @(negedge CLK); #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(fpu_enable), 32'd0);
    check("rst_op1", fpu_op1, 32'd0);
    check("rst_resp", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    req_valid = '0;

    // Stray completion while idle
    fpu_data_valid = 1'b1;
    fpu_result     = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK); #1;
      check("stray_idle_busy", 32'(busy), 32'd0);
      check("stray_idle_resp", 32'(resp_valid), 32'd0);
    end
    fpu_data_valid = 1'b0;

    do_op(3'b001, 4, 1'b0);
    do_op(3'b010, 1, 1'b1);
    for (int n = 0; n < 4; n++) do_op(3'b011, 2, 1'b0);
    for (int n = 0; n < 30; n++)
      do_op(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(1, 6), 1'($urandom_range(0, 1)));

    // Reset in WAIT aborts the operation
    req_valid = 3'b110;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_op1", fpu_op1, 32'd0);
    check("abort_result", resp_result, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    req_valid = '0;
    mptr = 0;
    fpu_data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      check("abort_noresp", 32'(resp_valid), 32'd0);
    end
    fpu_data_valid = 1'b0;
    do_op(3'b111, 2, 1'b0);

`ifdef FPU_ARB_TIMEOUT_EN
    do_op(3'b100, 0, 1'b0);
    do_op(3'b111, 3, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares the single-issue FPU between several independent requesters (APB slave interface, core coprocessor port, DMA engine) under round-robin arbitration. It accepts one operation at a time through a valid/ready handshake and latches the operands. It pulses the FPU enable, waits for the FPU's data_valid, and routes the result back to the requester that issued the operation. It sits between the requester ports and the FPU instance inside the FPU subsystem wrapper.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYCLES, 64: watchdog limit in WAIT; used only with FPU_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  single clock for all logic.
- RSTN  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_op1  in  NUM_REQ*32  operand 1; requester i owns bits [32i+31:32i].
- req_op2  in  NUM_REQ*32  operand 2, packed the same way.
- req_op_select  in  NUM_REQ*3  operation code; requester i owns bits [3i+2:3i].
- req_ready  out  NUM_REQ  accept strobe, one-hot or zero.
- resp_valid  out  NUM_REQ  one-cycle result strobe to the owning requester.
- resp_result  out  32  result, meaningful while any resp_valid bit is set.
- resp_error  out  1  timeout flag, qualified by resp_valid.
- busy  out  1  high in every state except IDLE.
- fpu_enable  out  1  one-cycle start pulse to the FPU.
- fpu_op1, fpu_op2  out  32  latched operands, stable from ISSUE through WAIT.
- fpu_op_select  out  3  latched operation code.
- fpu_result  in  32  FPU result.
- fpu_data_valid  in  1  FPU completion strobe.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid bit is set, the grant goes to the first requesting index at or after rr_ptr, searching with wrap-around.
  - req_ready[grant] is driven combinationally high in that cycle. The transfer is req_valid & req_ready.
  - On the transfer: latch op1, op2, op_select and the owner index, then go to ISSUE.
  - Set rr_ptr to (grant+1) mod NUM_REQ.
- ISSUE: drive fpu_enable=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On fpu_data_valid: capture fpu_result and go to RESP.
  - fpu_data_valid is ignored in every state except WAIT.
- RESP:
  - resp_valid[owner]=1 for one cycle, with resp_result set to the captured result. Then go to IDLE.
  - req_ready stays 0 in RESP. A new grant is made no earlier than the following IDLE cycle.
- Requesters hold valid and payload stable until ready. Deasserting valid before ready is legal and simply withdraws the request.
- Reset values: state=IDLE, rr_ptr=0, all latches 0, and every output 0.
- Reset during any state aborts the operation; no response is issued.

## Timing
- Accept in cycle T, fpu_enable in T+1, WAIT from T+2.
- If fpu_data_valid arrives in cycle D (D≥T+2), resp_valid is in D+1. The earliest response is T+3.
- If fpu_data_valid is high during ISSUE, it is ignored.
- Back-to-back throughput: one operation per (FPU latency + 3) cycles.
- Simultaneous requests: only one req_ready bit is set per cycle. Losers see ready=0 and keep waiting.
- Fairness: a continuously requesting port is granted within NUM_REQ operations.

## Configuration
- FPU_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no fpu_data_valid, go to RESP with resp_result=0 and resp_error=1.
- FPU_ARB_TIMEOUT_EN undefined:
  - There is no counter, and WAIT waits indefinitely.
  - resp_error is tied to 0, and the port is still present.

## Structure
- Shared package fpu_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - FPU_DATA_W=32 and FPU_OPSEL_W=3;
  - the default TIMEOUT_CYCLES.
- One sub-module, fpu_rr_arbiter. It takes req vector and rr_ptr and produces a one-hot grant plus an encoded index. It is purely combinational and parameterised by NUM_REQ.
- The FSM, latches and timeout counter live in fpu_arbiter.

## Test plan
- Single request: requester 0 sends op1=0x3F800000, op2=0x40000000, op_select=0, and a stub FPU answers 0x40400000 after 4 cycles. Expect fpu_enable at T+1 with latched operands, then resp_valid[0] at T+6 with resp_result=0x40400000 and resp_error=0.
- Contention: both requesters hold valid continuously from reset. Grants alternate 0,1,0,1; each resp_valid goes only to the owner.
- Ready gating: requester 1 asserts valid during WAIT of requester 0's operation. Expect req_ready[1]=0 until the IDLE cycle after RESP, then accept.
- Stray completion: pulse fpu_data_valid in IDLE and in ISSUE. Expect no resp_valid and no state change; the real completion later is returned normally.
- Reset mid-WAIT: drop RSTN while in WAIT. All outputs go to 0 immediately, with no resp_valid after release. The next grant goes to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): the FPU never answers. Expect resp_valid[owner] with resp_error=1 and resp_result=0 at T+11, then normal service resumes.
